rr_requester: RTL

//  Client-side agent for the 4-port round-robin arbiter: one instance per port.

---
 rtl/rr_requester.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rr_requester.sv
// Client-side agent for one port of a round-robin arbiter: buffers upstream words,
// requests the port, drains bounded bursts while granted, and flags starvation.
module rr_requester #(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid_i,
    input  logic [DATA_W-1:0]               in_data_i,
    output logic                            in_ready_o,
    output logic                            req_o,
    input  logic                            gnt_i,
    output logic                            out_valid_o,
    output logic [DATA_W-1:0]               out_data_o,
    output logic                            starve_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT+1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST-1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [BW-1:0]       r_beat;
    logic [BW-1:0]       w_beat_nxt;
    logic [SW-1:0]       r_starve_cnt;
    logic [SW-1:0]       w_starve_nxt;
    logic                r_starve;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                w_in_ready;
    logic                w_push;
    logic                w_pop;

    // Readiness looks only at the current count: a pop in the same cycle does
    // not free a slot until the next cycle.
    assign w_in_ready = (r_count < DEPTH_C);
    assign w_push     = in_valid_i & w_in_ready;
    assign w_pop      = (r_state == S_REQ) & gnt_i & (r_count != '0);

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Leave after the last allowed beat, or when this pop empties the FIFO.
                if (w_pop) begin
                    if ((r_beat == BEAT_LAST) || ((r_count == ONE_C) && !w_push)) begin
                        w_state_nxt = S_GAP;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt  = r_beat + 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_state_nxt = (r_count != '0) ? S_REQ : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (r_state == S_REQ) begin
            if (gnt_i) begin
                w_starve_nxt = '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                w_starve_nxt = r_starve_cnt + 1'b1;
            end
        end
        if (w_state_nxt == S_IDLE) begin
            w_starve_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_starve_cnt <= w_starve_nxt;
            // Flag reflects the counter value it is registered alongside.
            r_starve     <= (w_starve_nxt == STARVE_MAX);
            r_out_valid  <= w_pop;
            if (w_pop) begin
                r_out_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign req_o       = (r_state == S_REQ);
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign starve_o    = r_starve;
    assign count_o     = r_count;

endmodule
